// File: rtl/jtag_scan_ctrl_if.sv
// Host-side command/response handshake for jtag_scan_ctrl.
// The host is the master; the scan controller is the slave.
interface jtag_scan_ctrl_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [5:0]  cmd_len;
    logic [31:0] cmd_tdi;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_len, cmd_tdi, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_len, cmd_tdi, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/jtag_scan_ctrl.sv
// Command sequencer in front of jtag_proc: splits IR/DR scans, TAP
// reset and idle clocks into PRE/SHIFT/POST or SINGLE transactions.
module jtag_scan_ctrl #(
    parameter int unsigned C_TIMEOUT = 4096
) (
    input  logic            CLK,
    input  logic            RESETN,
    jtag_scan_ctrl_if.slave host,
    output logic            busy,
    output logic            proc_enable,
    input  logic            proc_done,
    output logic [31:0]     proc_length,
    output logic [31:0]     proc_tms,
    output logic [31:0]     proc_tdi,
    input  logic [31:0]     proc_tdo
);

    typedef enum logic [1:0] {
        S_IDLE, S_LAUNCH, S_WAIT_DONE, S_RESP
    } state_t;

    typedef enum logic [1:0] {
        PH_PRE, PH_SHIFT, PH_POST, PH_SINGLE
    } phase_t;

    typedef struct packed {
        logic [31:0] length;
        logic [31:0] tms;
        logic [31:0] tdi;
    } vec_t;

    localparam logic [1:0]  OP_DR    = 2'b00;
    localparam logic [1:0]  OP_IR    = 2'b01;
    localparam logic [1:0]  OP_RST   = 2'b10;
    localparam logic [15:0] TMO_LAST = 16'(C_TIMEOUT - 1);

    state_t      state, state_n;
    phase_t      phase, phase_n;
    logic [1:0]  op_q, op_n;
    logic [5:0]  len_q, len_n;
    logic [31:0] tdi_q, tdi_n;
    logic [31:0] data_q, data_n;
    logic        err_q, err_n;
    vec_t        vec_q, vec_n;
    logic [15:0] tmr, tmr_n;
    logic        load;

    // Valid only for n in 1..32; longer lengths never reach here.
    function automatic logic [31:0] len_mask(input logic [5:0] n);
        return 32'hFFFF_FFFF >> (6'd32 - n);
    endfunction

    function automatic vec_t plan(
        input phase_t      ph,
        input logic [1:0]  op,
        input logic [5:0]  n,
        input logic [31:0] d
    );
        vec_t v;
        v = '0;
        unique case (ph)
            PH_PRE: begin
                v.length = (op == OP_IR) ? 32'd4 : 32'd3;
                v.tms    = (op == OP_IR) ? 32'h3 : 32'h1;
            end
            PH_SHIFT: begin
                v.length = {26'd0, n};
                v.tms    = 32'h1 << (n - 6'd1);
                v.tdi    = d & len_mask(n);
            end
            PH_POST: begin
                v.length = 32'd2;
                v.tms    = 32'h1;
            end
            PH_SINGLE: begin
                v.length = (op == OP_RST) ? 32'd6 : {26'd0, n};
                v.tms    = (op == OP_RST) ? 32'h1F : 32'h0;
            end
        endcase
        return v;
    endfunction

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state  <= S_IDLE;
            phase  <= PH_PRE;
            op_q   <= '0;
            len_q  <= '0;
            tdi_q  <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
            vec_q  <= '0;
            tmr    <= '0;
        end else begin
            state  <= state_n;
            phase  <= phase_n;
            op_q   <= op_n;
            len_q  <= len_n;
            tdi_q  <= tdi_n;
            data_q <= data_n;
            err_q  <= err_n;
            vec_q  <= vec_n;
            tmr    <= tmr_n;
        end
    end

    always_comb begin
        state_n = state;
        phase_n = phase;
        op_n    = op_q;
        len_n   = len_q;
        tdi_n   = tdi_q;
        data_n  = data_q;
        err_n   = err_q;
        vec_n   = vec_q;
        tmr_n   = tmr;
        load    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (host.cmd_valid) begin
                    op_n   = host.cmd_op;
                    len_n  = host.cmd_len;
                    tdi_n  = host.cmd_tdi;
                    data_n = '0;
                    err_n  = 1'b0;
                    if (host.cmd_op != OP_RST &&
                        (host.cmd_len == 6'd0 || host.cmd_len > 6'd32)) begin
                        err_n   = 1'b1;
                        state_n = S_RESP;
                    end else begin
                        phase_n = (host.cmd_op == OP_DR || host.cmd_op == OP_IR)
                                  ? PH_PRE : PH_SINGLE;
                        state_n = S_LAUNCH;
                        load    = 1'b1;
                    end
                end
            end
            S_LAUNCH: begin
                tmr_n   = '0;
                state_n = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (proc_done) begin
                    unique case (phase)
                        PH_PRE: begin
                            phase_n = PH_SHIFT;
                            state_n = S_LAUNCH;
                            load    = 1'b1;
                        end
                        PH_SHIFT: begin
                            data_n  = proc_tdo & len_mask(len_q);
                            phase_n = PH_POST;
                            state_n = S_LAUNCH;
                            load    = 1'b1;
                        end
                        default: state_n = S_RESP;
                    endcase
                end else if (tmr == TMO_LAST) begin
                    err_n   = 1'b1;
                    state_n = S_RESP;
                end else begin
                    tmr_n = tmr + 16'd1;
                end
            end
            S_RESP: begin
                if (host.rsp_ready) state_n = S_IDLE;
            end
        endcase
        // Vectors are loaded on entry to LAUNCH and held through DONE.
        if (load) vec_n = plan(phase_n, op_n, len_n, tdi_n);
    end

    assign host.cmd_ready = (state == S_IDLE);
    assign host.rsp_valid = (state == S_RESP);
    assign host.rsp_data  = data_q;
    assign host.rsp_err   = err_q;
    assign busy           = (state != S_IDLE);
    assign proc_enable    = (state == S_LAUNCH);
    assign proc_length    = vec_q.length;
    assign proc_tms       = vec_q.tms;
    assign proc_tdi       = vec_q.tdi;

endmodule

// File: tb/tb_jtag_scan_ctrl.sv
// Randomized bench for jtag_scan_ctrl with a jtag_proc responder
// and a 16-state TAP walker as the reference model.
module tb_jtag_scan_ctrl;
    localparam int TMO = 16;

    logic        CLK = 1'b0;
    logic        RESETN = 1'b0;
    logic        busy;
    logic        proc_enable;
    logic        proc_done;
    logic [31:0] proc_length;
    logic [31:0] proc_tms;
    logic [31:0] proc_tdi;
    logic [31:0] proc_tdo;

    jtag_scan_ctrl_if host();

    jtag_scan_ctrl #(.C_TIMEOUT(TMO)) dut (
        .CLK         (CLK),
        .RESETN      (RESETN),
        .host        (host),
        .busy        (busy),
        .proc_enable (proc_enable),
        .proc_done   (proc_done),
        .proc_length (proc_length),
        .proc_tms    (proc_tms),
        .proc_tdi    (proc_tdi),
        .proc_tdo    (proc_tdo)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    localparam int TLR = 0, RTI = 1, SDR = 2, CDR = 3, SHDR = 4, E1DR = 5;
    localparam int PDR = 6, E2DR = 7, UDR = 8, SIR = 9, CIR = 10;
    localparam int SHIR = 11, E1IR = 12, PIR = 13, E2IR = 14, UIR = 15;

    function automatic int tap_next(input int s, input bit m);
        case (s)
            TLR:        return m ? TLR  : RTI;
            RTI:        return m ? SDR  : RTI;
            SDR:        return m ? SIR  : CDR;
            CDR, SHDR:  return m ? E1DR : SHDR;
            E1DR:       return m ? UDR  : PDR;
            PDR:        return m ? E2DR : PDR;
            E2DR:       return m ? UDR  : SHDR;
            UDR, UIR:   return m ? SDR  : RTI;
            SIR:        return m ? TLR  : CIR;
            CIR, SHIR:  return m ? E1IR : SHIR;
            E1IR:       return m ? UIR  : PIR;
            PIR:        return m ? E2IR : PIR;
            E2IR:       return m ? UIR  : SHIR;
            default:    return TLR;
        endcase
    endfunction

    int          tap = TLR;
    logic [31:0] ir_sh = '0;
    logic [31:0] ir_upd = '0;

    task automatic tap_run(input int unsigned len, input logic [31:0] tms,
                           input logic [31:0] tdi);
        for (int i = 0; i < int'(len) && i < 32; i++) begin
            if (tap == SHIR) ir_sh = {tdi[i], ir_sh[31:1]};
            tap = tap_next(tap, tms[i]);
            if (tap == UIR) ir_upd = ir_sh;
        end
    endtask

    typedef struct {
        int unsigned len;
        logic [31:0] tms;
        logic [31:0] tdi;
        int          at;
    } lrec_t;

    int          cyc = 0;
    lrec_t       lq[$];
    int          dq_at[$];
    logic [31:0] dq_tdo[$];
    int          mute_idx = -1;
    bit          tdo_fix_en = 1'b0;
    logic [31:0] tdo_fix = '0;
    bit          pend;
    int          cnt;
    lrec_t       cur;
    logic [31:0] last_data;

    always @(posedge CLK) cyc <= cyc + 1;

    // jtag_proc stand-in: random DONE latency, random TDO.
    always @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            proc_done <= 1'b0;
            proc_tdo  <= '0;
            pend      <= 1'b0;
            cnt       <= 0;
        end else begin
            proc_done <= 1'b0;
            if (proc_done) begin
                dq_at.push_back(cyc);
                dq_tdo.push_back(proc_tdo);
            end
            if (pend) begin
                chk("enable_while_busy", {31'd0, proc_enable}, 32'd0);
                chk("hold_length", proc_length, cur.len);
                chk("hold_tms", proc_tms, cur.tms);
                chk("hold_tdi", proc_tdi, cur.tdi);
                if (cnt == 0) begin
                    proc_done <= 1'b1;
                    proc_tdo  <= tdo_fix_en ? tdo_fix : $urandom;
                    pend      <= 1'b0;
                end else begin
                    cnt <= cnt - 1;
                end
            end else if (proc_enable) begin
                cur.len = proc_length;
                cur.tms = proc_tms;
                cur.tdi = proc_tdi;
                cur.at  = cyc;
                lq.push_back(cur);
                tap_run(cur.len, cur.tms, cur.tdi);
                if (lq.size() - 1 != mute_idx) begin
                    pend <= 1'b1;
                    cnt  <= $urandom_range(0, 5);
                end
            end
        end
    end

    task automatic run_cmd(input logic [1:0] op, input logic [5:0] n,
                           input logic [31:0] d, input bit to,
                           input int hold);
        lrec_t       ex[$];
        lrec_t       r;
        bit          lerr;
        logic [31:0] m;
        logic [31:0] exp_data;
        int          acc;
        int          rv;
        int          w;
        lerr = (op != 2'b10) && (n == 6'd0 || n > 6'd32);
        m = (n >= 6'd32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
        r.at = 0;
        if (!lerr) begin
            case (op)
                2'b00, 2'b01: begin
                    r.len = (op == 2'b01) ? 4 : 3;
                    r.tms = (op == 2'b01) ? 32'h3 : 32'h1;
                    r.tdi = 0;
                    ex.push_back(r);
                    r.len = n;
                    r.tms = 32'h1 << (n - 6'd1);
                    r.tdi = d & m;
                    ex.push_back(r);
                    r.len = 2; r.tms = 32'h1; r.tdi = 0;
                    ex.push_back(r);
                end
                2'b10: begin
                    r.len = 6; r.tms = 32'h1F; r.tdi = 0;
                    ex.push_back(r);
                end
                default: begin
                    r.len = n; r.tms = 0; r.tdi = 0;
                    ex.push_back(r);
                end
            endcase
        end
        lq.delete();
        dq_at.delete();
        dq_tdo.delete();
        @(negedge CLK);
        chk("cmd_ready_idle", {31'd0, host.cmd_ready}, 32'd1);
        host.cmd_valid = 1'b1;
        host.cmd_op    = op;
        host.cmd_len   = n;
        host.cmd_tdi   = d;
        acc = cyc;
        @(negedge CLK);
        host.cmd_valid = 1'b0;
        host.cmd_len   = 6'($urandom);
        host.cmd_tdi   = $urandom;
        w = 0;
        while (!host.rsp_valid && w < 500) begin
            @(negedge CLK);
            w++;
        end
        chk("rsp_arrives", {31'd0, host.rsp_valid}, 32'd1);
        rv = cyc;
        if (lerr) begin
            chk("lerr_latency", rv, acc + 1);
            chk("lerr_no_launch", lq.size(), 0);
        end else if (to) begin
            chk("to_launches", lq.size(), 1);
            if (lq.size() > 0) chk("to_latency", rv, lq[0].at + TMO + 1);
        end else begin
            chk("n_launches", lq.size(), ex.size());
            if (dq_at.size() > 0) chk("done_latency", rv, dq_at[$] + 1);
            if (lq.size() > 0) chk("accept_latency", lq[0].at, acc + 1);
            for (int i = 0; i < lq.size() && i < ex.size(); i++) begin
                chk("launch_len", lq[i].len, ex[i].len);
                chk("launch_tms", lq[i].tms, ex[i].tms);
                chk("launch_tdi", lq[i].tdi, ex[i].tdi);
                if (i > 0 && dq_at.size() >= i)
                    chk("launch_spacing", lq[i].at, dq_at[i-1] + 1);
            end
            chk("tap_in_idle", tap, RTI);
        end
        exp_data = 0;
        if (!lerr && !to && op[1] == 1'b0 && dq_tdo.size() > 1)
            exp_data = dq_tdo[1] & m;
        chk("rsp_data", host.rsp_data, exp_data);
        chk("rsp_err", {31'd0, host.rsp_err}, {31'd0, lerr | to});
        last_data = host.rsp_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge CLK);
            chk("bp_valid", {31'd0, host.rsp_valid}, 32'd1);
            chk("bp_data", host.rsp_data, exp_data);
            chk("bp_ready", {31'd0, host.cmd_ready}, 32'd0);
        end
        host.rsp_ready = 1'b1;
        @(negedge CLK);
        host.rsp_ready = 1'b0;
        chk("post_rsp_ready", {31'd0, host.cmd_ready}, 32'd1);
        chk("post_rsp_valid", {31'd0, host.rsp_valid}, 32'd0);
    endtask

    task automatic chk_reset_vals();
        chk("rst_cmd_ready", {31'd0, host.cmd_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rsp_valid", {31'd0, host.rsp_valid}, 32'd0);
        chk("rst_rsp_err", {31'd0, host.rsp_err}, 32'd0);
        chk("rst_rsp_data", host.rsp_data, 32'd0);
        chk("rst_enable", {31'd0, proc_enable}, 32'd0);
        chk("rst_length", proc_length, 32'd0);
        chk("rst_tms", proc_tms, 32'd0);
        chk("rst_tdi", proc_tdi, 32'd0);
    endtask

    initial begin
        int w;
        logic [5:0] n;
        host.cmd_valid = 1'b0;
        host.cmd_op    = '0;
        host.cmd_len   = '0;
        host.cmd_tdi   = '0;
        host.rsp_ready = 1'b0;
        repeat (3) @(negedge CLK);
        chk_reset_vals();
        RESETN = 1'b1;

        run_cmd(2'b10, 6'd0, 32'h0, 1'b0, 0);
        tdo_fix_en = 1'b1;
        tdo_fix    = 32'hFFFF_FF3C;
        run_cmd(2'b00, 6'd8, 32'h1A5, 1'b0, 0);
        chk("dr_example_data", last_data, 32'h3C);
        tdo_fix_en = 1'b0;
        run_cmd(2'b01, 6'd32, 32'hDEAD_BEEF, 1'b0, 0);
        chk("ir_value", ir_upd, 32'hDEAD_BEEF);
        run_cmd(2'b11, 6'd5, 32'hFFFF_FFFF, 1'b0, 0);
        run_cmd(2'b00, 6'd0, 32'h1234, 1'b0, 0);
        run_cmd(2'b01, 6'd33, 32'h1234, 1'b0, 0);
        run_cmd(2'b00, 6'd1, 32'hFFFF_FFFF, 1'b0, 0);
        run_cmd(2'b01, 6'd20, $urandom, 1'b0, 10);

        mute_idx = 0;
        run_cmd(2'b00, 6'd8, $urandom, 1'b1, 0);
        mute_idx = -1;
        run_cmd(2'b10, 6'd0, 32'h0, 1'b0, 0);

        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 9) == 0)
                n = $urandom_range(0, 1) == 0 ? 6'd0 : 6'($urandom_range(33, 63));
            else
                n = 6'($urandom_range(1, 32));
            run_cmd(2'($urandom_range(0, 3)), n, $urandom, 1'b0,
                    $urandom_range(0, 3));
        end

        mute_idx = 1;
        lq.delete();
        @(negedge CLK);
        host.cmd_valid = 1'b1;
        host.cmd_op    = 2'b00;
        host.cmd_len   = 6'd16;
        host.cmd_tdi   = $urandom;
        @(negedge CLK);
        host.cmd_valid = 1'b0;
        w = 0;
        while (lq.size() < 2 && w < 100) begin
            @(negedge CLK);
            w++;
        end
        chk("shift_launched", lq.size(), 2);
        repeat (3) @(negedge CLK);
        chk("busy_in_shift", {31'd0, busy}, 32'd1);
        #2 RESETN = 1'b0;
        #1 chk_reset_vals();
        @(negedge CLK);
        RESETN = 1'b1;
        mute_idx = -1;
        run_cmd(2'b10, 6'd0, 32'h0, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog got=%0d exp=%0d", cyc, 0);
        $fatal(1, "watchdog expired");
    end
endmodule
